// File: rtl/bpsk_phase_sequencer_if.sv
// AXI-Stream style handshake bundle shared by the byte input and phase output.
//   tdata  : payload (DATA_W bits)
//   tvalid : payload valid
//   tlast  : final beat of a packet
//   tready : sink accepts the beat
// master drives payload/valid/last; slave drives ready.
interface bpsk_phase_sequencer_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/bpsk_phase_sequencer.sv
// BPSK phase sequencer: serialises bytes MSB-first, one bit per symbol of
// SAMPLES_PER_SYMBOL samples, emitting accumulator phase + 180 deg for bit 1.
// Ports:
//   M_AXIS_ACLK    : clock
//   M_AXIS_ARESETN : synchronous active-low reset
//   s_axis         : byte input stream (8-bit tdata, bit 7 sent first)
//   m_axis         : 16-bit phase word output stream
//   busy           : high while sending samples
//   underrun_cnt   : saturating count of mid-packet input starvation events
module bpsk_phase_sequencer #(
  parameter logic [31:0] PHASE_STEP         = 32'd67108864,
  parameter int unsigned SAMPLES_PER_SYMBOL = 16,
  parameter int unsigned C_M_START_COUNT    = 32,
  parameter int unsigned CNT_WIDTH          = 16
) (
  input  logic                   M_AXIS_ACLK,
  input  logic                   M_AXIS_ARESETN,
  bpsk_phase_sequencer_if.slave  s_axis,
  bpsk_phase_sequencer_if.master m_axis,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   underrun_cnt
);

  localparam int unsigned SC_W   = $clog2(SAMPLES_PER_SYMBOL);
  localparam int unsigned INIT_W = (C_M_START_COUNT > 1) ? $clog2(C_M_START_COUNT) : 1;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  logic [1:0]           state_q,  state_d;
  logic [INIT_W-1:0]    init_q,   init_d;
  logic [7:0]           nbuf_q,   nbuf_d;
  logic                 nlast_q,  nlast_d;
  logic                 nvalid_q, nvalid_d;
  logic [7:0]           shift_q,  shift_d;
  logic                 last_q,   last_d;
  logic [2:0]           bit_q,    bit_d;
  logic [SC_W-1:0]      sample_q, sample_d;
  logic [31:0]          phase_q,  phase_d;
  logic [CNT_WIDTH-1:0] under_q,  under_d;
  logic [15:0]          tdata_q,  tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q,  tlast_d;
  logic                 tready_q, tready_d;
  logic                 busy_q,   busy_d;

  logic s_hs, m_hs, sym_end, byte_end;

  // State and output registers
  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      state_q  <= ST_INIT;
      init_q   <= '0;
      nbuf_q   <= '0;
      nlast_q  <= 1'b0;
      nvalid_q <= 1'b0;
      shift_q  <= '0;
      last_q   <= 1'b0;
      bit_q    <= '0;
      sample_q <= '0;
      phase_q  <= '0;
      under_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      init_q   <= init_d;
      nbuf_q   <= nbuf_d;
      nlast_q  <= nlast_d;
      nvalid_q <= nvalid_d;
      shift_q  <= shift_d;
      last_q   <= last_d;
      bit_q    <= bit_d;
      sample_q <= sample_d;
      phase_q  <= phase_d;
      under_q  <= under_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tready_q <= tready_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic; outputs are registered from the next-state values
  always_comb begin
    state_d  = state_q;
    init_d   = init_q;
    nbuf_d   = nbuf_q;
    nlast_d  = nlast_q;
    nvalid_d = nvalid_q;
    shift_d  = shift_q;
    last_d   = last_q;
    bit_d    = bit_q;
    sample_d = sample_q;
    phase_d  = phase_q;
    under_d  = under_q;

    s_hs     = s_axis.tvalid && tready_q;
    m_hs     = tvalid_q && m_axis.tready;
    sym_end  = (sample_q == SC_W'(SAMPLES_PER_SYMBOL - 1));
    byte_end = sym_end && (bit_q == 3'd7);

    // tready is only high while the buffer is empty, so a load never races a fill
    if (s_hs) begin
      nbuf_d   = s_axis.tdata;
      nlast_d  = s_axis.tlast;
      nvalid_d = 1'b1;
    end

    case (state_q)
      ST_INIT: begin
        if (init_q == INIT_W'(C_M_START_COUNT - 1)) state_d = ST_IDLE;
        else                                          init_d  = init_q + INIT_W'(1);
      end
      ST_IDLE: begin
        if (nvalid_q) begin
          shift_d  = nbuf_q;
          last_d   = nlast_q;
          bit_d    = '0;
          sample_d = '0;
          nvalid_d = 1'b0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (m_hs) begin
          // A packet's final beat rewinds the accumulator; underruns keep it running
          phase_d = (byte_end && last_q) ? 32'd0 : phase_q + PHASE_STEP;
          if (!sym_end) begin
            sample_d = sample_q + SC_W'(1);
          end else begin
            sample_d = '0;
            if (!byte_end) begin
              shift_d = {shift_q[6:0], 1'b0};
              bit_d   = bit_q + 3'd1;
            end else begin
              if (nvalid_q) begin
                shift_d  = nbuf_q;
                last_d   = nlast_q;
                bit_d    = '0;
                nvalid_d = 1'b0;
              end else begin
                state_d = ST_IDLE;
              end
              if (!nvalid_q && !last_q && !(&under_q)) under_d = under_q + CNT_WIDTH'(1);
            end
          end
        end
      end
      default: state_d = ST_INIT;
    endcase

    tvalid_d = (state_d == ST_SEND);
    busy_d   = (state_d == ST_SEND);
    tdata_d  = phase_d[31:16] ^ {shift_d[7], 15'd0};
    tlast_d  = tvalid_d && last_d && (bit_d == 3'd7) &&
               (sample_d == SC_W'(SAMPLES_PER_SYMBOL - 1));
    tready_d = !nvalid_d && (state_d != ST_INIT);
  end

  assign s_axis.tready = tready_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign busy          = busy_q;
  assign underrun_cnt  = under_q;

endmodule

// File: tb/tb_bpsk_phase_sequencer.sv
// Scoreboard bench for bpsk_phase_sequencer: a small phase model pushes the
// expected beats when each byte is offered; a negedge monitor pops and compares.
module tb_bpsk_phase_sequencer;

  localparam int unsigned SPS   = 4;
  localparam logic [31:0] STEP  = 32'h0400_0000;
  localparam int unsigned START = 32;
  localparam int unsigned CW    = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          busy;
  logic [CW-1:0] underrun_cnt;
  logic          bp_en = 1'b0;

  bpsk_phase_sequencer_if #(.DATA_W(8))  s_if();
  bpsk_phase_sequencer_if #(.DATA_W(16)) m_if();

  bpsk_phase_sequencer #(
    .PHASE_STEP(STEP), .SAMPLES_PER_SYMBOL(SPS),
    .C_M_START_COUNT(START), .CNT_WIDTH(CW)
  ) dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rstn),
    .s_axis(s_if), .m_axis(m_if),
    .busy(busy), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Phase model and scoreboard
  logic [16:0] sb[$];
  logic [31:0] mphase = 32'd0;

  task automatic push_byte(input logic [7:0] d, input logic l);
    logic [15:0] w;
    for (int b = 7; b >= 0; b--) begin
      for (int s = 0; s < int'(SPS); s++) begin
        w = mphase[31:16] ^ (d[b] ? 16'h8000 : 16'h0000);
        sb.push_back({l && (b == 0) && (s == int'(SPS) - 1), w});
        mphase = mphase + STEP;
      end
    end
    if (l) mphase = 32'd0;
  endtask

  // Downstream ready: always 1, or random when backpressure is enabled
  initial m_if.tready = 1'b1;
  always @(posedge clk) begin
    #1;
    m_if.tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor
  int          beat_cnt  = 0;
  int          tlast_cnt = 0;
  int          gap_cnt   = 0;
  int          stall_cnt = 0;
  logic        in_pkt    = 1'b0;
  logic        prev_stall = 1'b0;
  logic [16:0] prev_beat = '0;
  logic [15:0] beat_log [64];
  logic        tlast_log[64];

  always @(negedge clk) begin
    logic [16:0] exp_beat;
    if (!rstn) begin
      prev_stall = 1'b0;
      in_pkt     = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", 32'({m_if.tvalid, m_if.tlast, m_if.tdata}),
                            32'({1'b1, prev_beat}));
      if (m_if.tvalid && m_if.tready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'(sb.size()), 32'(1));
        end else begin
          exp_beat = sb.pop_front();
          check("beat", 32'({m_if.tlast, m_if.tdata}), 32'(exp_beat));
        end
        if (beat_cnt < 64) begin
          beat_log[beat_cnt]  = m_if.tdata;
          tlast_log[beat_cnt] = m_if.tlast;
        end
        beat_cnt++;
        if (m_if.tlast) tlast_cnt++;
        in_pkt = !m_if.tlast;
      end else if (in_pkt && !m_if.tvalid) begin
        gap_cnt++;
      end
      if (m_if.tvalid && !m_if.tready) stall_cnt++;
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_beat  = {m_if.tlast, m_if.tdata};
    end
  end

  task automatic clear_stats();
    beat_cnt  = 0;
    tlast_cnt = 0;
    gap_cnt   = 0;
    stall_cnt = 0;
  endtask

  // Offer one byte and wait for its handshake
  task automatic send_byte(input logic [7:0] d, input logic l);
    logic done;
    done = 1'b0;
    push_byte(d, l);
    @(posedge clk); #1;
    s_if.tdata = d; s_if.tlast = l; s_if.tvalid = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (s_if.tready) done = 1'b1;
    end
    check("send_handshake", 32'(done), 32'(1));
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
  endtask

  // Wait until every expected beat has been seen and the output has gone idle
  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !m_if.tvalid) done = 1'b1;
    end
    check("drain", 32'(done), 32'(1));
  endtask

  // Release reset with a byte already offered; check the start-up hold-off
  task automatic startup_with_byte(input logic [7:0] d, input logic l);
    int early, vbad;
    early = 0; vbad = 0;
    push_byte(d, l);
    s_if.tdata = d; s_if.tlast = l; s_if.tvalid = 1'b1;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 1; k <= int'(START); k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < int'(START) && s_if.tready) early++;
      if (m_if.tvalid) vbad++;
    end
    check("startup_tready_low", 32'(early), 32'(0));
    check("startup_tready_high", 32'(s_if.tready), 32'(1));
    check("startup_no_tvalid", 32'(vbad), 32'(0));
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 32'(m_if.tvalid), 32'(0));
    check("rst_tlast", 32'(m_if.tlast), 32'(0));
    check("rst_tdata", 32'(m_if.tdata), 32'(0));
    check("rst_tready", 32'(s_if.tready), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_underrun", 32'(underrun_cnt), 32'(0));

    // Single byte 0x80, last
    clear_stats();
    startup_with_byte(8'h80, 1'b1);
    wait_drain();
    check("single_beats", 32'(beat_cnt), 32'(32));
    check("single_b0", 32'(beat_log[0]), 32'h8000);
    check("single_b1", 32'(beat_log[1]), 32'h8400);
    check("single_b2", 32'(beat_log[2]), 32'h8800);
    check("single_b3", 32'(beat_log[3]), 32'h8C00);
    check("single_b4", 32'(beat_log[4]), 32'h1000);
    check("single_b31", 32'(beat_log[31]), 32'h7C00);
    check("single_tlast31", 32'(tlast_log[31]), 32'(1));
    check("single_busy_low", 32'(busy), 32'(0));

    // Back-to-back 0xFF then 0x00 (last)
    clear_stats();
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b1);
    wait_drain();
    check("b2b_beats", 32'(beat_cnt), 32'(64));
    check("b2b_gaps", 32'(gap_cnt), 32'(0));
    check("b2b_b32", 32'(beat_log[32]), 32'h8000);
    check("b2b_tlast_cnt", 32'(tlast_cnt), 32'(1));
    check("b2b_tlast63", 32'(tlast_log[63]), 32'(1));
    check("b2b_underrun", 32'(underrun_cnt), 32'(0));

    // Random backpressure on 0xA5
    clear_stats();
    bp_en = 1'b1;
    send_byte(8'hA5, 1'b1);
    wait_drain();
    bp_en = 1'b0;
    check("bp_beats", 32'(beat_cnt), 32'(32));
    check("bp_stalls_seen", 32'(stall_cnt != 0), 32'(1));

    // Underrun: non-last byte with nothing following
    clear_stats();
    send_byte(8'h0F, 1'b0);
    wait_drain();
    check("ur_beats", 32'(beat_cnt), 32'(32));
    check("ur_tlast_cnt", 32'(tlast_cnt), 32'(0));
    check("ur_count", 32'(underrun_cnt), 32'(1));
    clear_stats();
    send_byte(8'h3C, 1'b1);
    wait_drain();
    check("ur_resume_b0", 32'(beat_log[0]), 32'h8000);
    check("ur_count_hold", 32'(underrun_cnt), 32'(1));

    // Reset at beat 10 of a packet
    clear_stats();
    send_byte(8'h55, 1'b1);
    for (int i = 0; i < 500 && beat_cnt < 10; i++) @(negedge clk);
    check("mid_reach_beat10", 32'(beat_cnt >= 10), 32'(1));
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_tvalid", 32'(m_if.tvalid), 32'(0));
    check("mid_rst_underrun", 32'(underrun_cnt), 32'(0));
    check("mid_rst_tready", 32'(s_if.tready), 32'(0));
    sb.delete();
    mphase = 32'd0;
    repeat (2) @(posedge clk);
    clear_stats();
    startup_with_byte(8'h7E, 1'b1);
    wait_drain();
    check("mid_new_beats", 32'(beat_cnt), 32'(32));
    check("mid_new_b0", 32'(beat_log[0]), 32'h0000);
    check("mid_new_b4", 32'(beat_log[4]), 32'h9000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bpsk_phase_sequencer.md
Name: bpsk_phase_sequencer

Overview:
- Sequences the phase-accumulator datapath for BPSK modulation.
- Accepts a byte stream over AXI-Stream and serialises it MSB-first, one bit per symbol of SAMPLES_PER_SYMBOL samples.
- Emits a 16-bit phase word per sample: accumulator phase plus 180 degrees when the current bit is 1.
- Sits between the packet source (DMA/FIFO) and the phase-to-amplitude stage feeding the RF DAC path.

Parameters:
- PHASE_STEP, 32'd67108864, per-sample accumulator increment (Fout/Fs * 2^32).
- SAMPLES_PER_SYMBOL, 16, output samples per bit; legal range 2..256.
- C_M_START_COUNT, 32, cycles waited after reset before any handshake.
- CNT_WIDTH, 16, width of underrun counter.

Ports:
- M_AXIS_ACLK  in  1  sole clock.
- M_AXIS_ARESETN  in  1  reset, synchronous, active-low.
- S_AXIS_TDATA  in  8  payload byte; bit 7 transmitted first.
- S_AXIS_TVALID  in  1  byte valid.
- S_AXIS_TLAST  in  1  byte is last of packet.
- S_AXIS_TREADY  out  1  byte accepted when high with TVALID.
- M_AXIS_TDATA  out  16  phase word.
- M_AXIS_TVALID  out  1  phase word valid.
- M_AXIS_TLAST  out  1  last sample of last bit of packet.
- M_AXIS_TREADY  in  1  downstream accepts sample.
- busy  out  1  high in SEND.
- underrun_cnt  out  CNT_WIDTH  saturating count of mid-packet input starvation events.

Behaviour:
- One clock (M_AXIS_ACLK); reset M_AXIS_ARESETN synchronous, active-low.
- Reset values: all outputs 0; phase_acc=0; state=INIT; next-byte buffer empty.
- States:
  - INIT: count 0..C_M_START_COUNT-1, then IDLE. S_AXIS_TREADY=0.
  - IDLE: if nbuf_valid, load shift reg, last flag and cur_bit (nbuf[7]) from nbuf, clear nbuf_valid, go to SEND; bit_idx=0, sample_cnt=0.
  - SEND: output samples.
- Input buffer: one-byte register nbuf/nbuf_last.
  - S_AXIS_TREADY = !nbuf_valid && state!=INIT, registered.
  - A handshake sets nbuf_valid.
  - Loading nbuf into the shift register and accepting a new byte in the same cycle is not possible (TREADY low while full). The refill arrives within 8*SAMPLES_PER_SYMBOL cycles, which is ample.
- Output (SEND): M_AXIS_TVALID=1; M_AXIS_TDATA = phase_acc[31:16] with bit 15 XORed by cur_bit. Outputs are driven from registers; no combinational path from M_AXIS_TREADY to TDATA/TVALID.
- Stall: while TVALID && !TREADY, TDATA, TLAST and all state hold stable.
- On each output handshake:
  - phase_acc += PHASE_STEP, modulo 2^32 (wraps silently).
  - If sample_cnt == SAMPLES_PER_SYMBOL-1: sample_cnt=0 and advance to the next bit. Otherwise sample_cnt++.
- Byte end (handshake with bit_idx==7 and sample_cnt==SAMPLES_PER_SYMBOL-1):
  - M_AXIS_TLAST is high on this beat iff the byte's last flag is set.
  - If nbuf_valid: load the next byte in the same cycle; no TVALID gap.
  - Else: go to IDLE; TVALID falls next cycle.
  - If that byte was not last (starvation mid-packet): underrun_cnt++ (saturating at all-ones).
- Packet start: when leaving IDLE after a byte flagged last, or after reset, phase_acc restarts at 0. After an underrun, phase_acc continues (phase-continuous).
- TLAST asserted only on the single final beat of a packet.
- Reset mid-operation: all state, buffered byte and counters clear next edge; in-flight data dropped; INIT wait repeats.

Test Plan:
- Startup: release reset, hold S_AXIS_TVALID=1 -> S_AXIS_TREADY=0 for C_M_START_COUNT cycles after reset release, then 1; no M_AXIS_TVALID before the first byte.
- Single byte, SAMPLES_PER_SYMBOL=4, PHASE_STEP=0x04000000, byte 0x80 TLAST=1, TREADY=1 -> 32 beats:
  - beats 0..3 = 0x8000, 0x8400, 0x8800, 0x8C00;
  - beat 4 = 0x1000;
  - beat 31 = 0x7C00 with TLAST=1, busy falls after.
- Back-to-back, same settings: bytes 0xFF then 0x00 with TLAST on second -> 64 contiguous beats with no TVALID gap; beat 32 = 0x8000 (bit 0, accumulator continues); TLAST only on beat 63.
- Backpressure: toggle M_AXIS_TREADY randomly during 0xA5 -> TDATA stable while stalled; the accepted-beat sequence equals the no-stall sequence.
- Underrun: byte 0x0F TLAST=0 then no input -> 32 beats, TLAST never high, underrun_cnt=1. A following byte resumes at phase 0x8000 (continuous, not reset).
- Reset mid-packet: assert reset at beat 10 of a packet -> M_AXIS_TVALID=0 and underrun_cnt=0 next cycle. After the INIT wait, a new packet starts with phase 0x0000 or 0x8000 per its first bit.
